ee354_2048_btn_ctrl: RTL and testbench
======================================

# ee354_2048_btn_ctrl

Front-end move generator for the 2048 game state machine. It turns four raw, bouncing push-button inputs into clean, one-hot, single-cycle `up`/`down`/`left`/`right` move pulses. It issues a move only while the game FSM reports `q_Wait`, then tracks the FSM's WAIT→move→WAIT handshake before accepting another press. Holding a button never produces repeated moves.

## Interface
- `DB_LIMIT`, default 500000: consecutive stable cycles required to accept a button level change (5 ms at 100 MHz).
- `DB_W`, default 19: debounce counter width; must satisfy 2^DB_W > DB_LIMIT.
- `ACK_TIMEOUT`, default 4: cycles to wait for `q_Wait` to fall after a pulse.

Ports:
- `Clk` in 1: system clock. All logic is on the rising edge.
- `Reset_n` in 1: asynchronous, active-low reset.
- `BtnU`, `BtnD`, `BtnL`, `BtnR` in 1 each: raw asynchronous buttons; high = pressed.
- `q_Wait` in 1: game FSM WAIT-state flag.
- `up`, `down`, `left`, `right` out 1 each: registered move pulses; at most one is high in any cycle.
- `busy` out 1: high in any state other than IDLE.
- `last_dir` out 2: direction of the most recent issued move (0=U, 1=D, 2=L, 3=R).
- `move_count` out 16: count of issued moves; wraps at 16'hFFFF→0.
- `ack_err` out 1: sticky flag; set when an ACK timeout occurs.

## Operation
- **Per-button pipeline:** 2-flop synchronizer `s1`→`s2`.
  - The debounce counter clears whenever `s2 == stable`.
  - Otherwise it increments. When it reaches `DB_LIMIT-1`, `stable <= s2` and the counter clears.
  - Any mismatch break before then restarts the count.
- **Press detect:** `press = stable & ~stable_d`, one cycle wide.
  - A press is captured only in IDLE with `q_Wait`=1.
  - A press occurring in any other state, or while `q_Wait`=0, is discarded. It is not queued.
- **FSM states:** IDLE, ISSUE, ACK_WAIT, RELEASE.
  - **IDLE:** if `q_Wait` and any press, select a direction by fixed priority U > D > L > R, then go to ISSUE. Otherwise stay.
  - **ISSUE:** assert exactly one output for this one cycle. Load `last_dir`, increment `move_count`, go to ACK_WAIT.
  - **ACK_WAIT:** if `q_Wait`=0, go to RELEASE. If `q_Wait` stays 1 for `ACK_TIMEOUT` cycles, set `ack_err` and go to RELEASE.
  - **RELEASE:** go to IDLE when `q_Wait`=1 and all four `stable`=0. If the game sits in WIN/LOSE, `q_Wait` stays 0 and the block remains in RELEASE.
- **Simultaneous presses:** only the highest-priority direction issues. The others are dropped and need a fresh release and press.
- **Bounce during ISSUE/ACK_WAIT/RELEASE:** has no effect on outputs.

## Timing
- **Reset values (immediate on `Reset_n`=0, independent of `Clk`):** all outputs 0, FSM=IDLE, `s1`/`s2`/`stable`/`stable_d`/counters 0, `last_dir`=0, `move_count`=0, `ack_err`=0.
- **Reset mid-operation:** an in-flight pulse is dropped. `up`/`down`/`left`/`right` are 0 from the reset assertion onward.
- **Latency:** from the first `Clk` edge sampling a raw button high (held clean) to the output pulse is `DB_LIMIT`+4 cycles, with `q_Wait`=1 throughout.
- **Pulse width:** exactly 1 cycle. `move_count` and `last_dir` update on the same edge that raises the pulse.
- **Handshake:** the game FSM samples the pulse while in WAIT and drops `q_Wait` the next cycle. The minimum spacing between two issued moves is 4 cycles plus the debounce time of the second press.
- **Release debounce:** a glitch shorter than `DB_LIMIT` cycles in either direction never changes `stable`.

## Test plan
Run with `DB_LIMIT`=4, `ACK_TIMEOUT`=4, and a behavioural WAIT model (drops `q_Wait` 1 cycle after a pulse, restores it 2 cycles later).
- **Clean press:** hold `BtnL` high 20 cycles, then release → `left` is high for exactly 1 cycle at cycle 8; `last_dir`=2; `move_count`=1; no further pulses while held.
- **Bounce:** toggle `BtnU` 1/0 every 2 cycles for 12 cycles, then hold high → a single `up` pulse occurs 8 cycles after the final rising transition; `move_count`=1.
- **Simultaneous press:** raise `BtnD` and `BtnR` on the same cycle → only `down` pulses. Release both, then press `BtnR` alone → `right` pulses; `move_count`=2.
- **Stalled FSM:** hold `q_Wait`=1 permanently and press `BtnU` → `up` pulses once. `ack_err`=1 after 4 cycles, FSM returns to IDLE on release, and a second press issues again.
- **Game-over stall and reset:** drop `q_Wait` to 0 permanently after a move, then press `BtnD` → no pulse and `busy` stays 1. Assert `Reset_n`=0 mid-stall → all outputs 0 and `move_count`=0 immediately.
- **Counter wrap:** force `move_count`=16'hFFFF, then issue a move → `move_count`=0.

Source files
------------

// File: rtl/ee354_2048_btn_ctrl.sv
// ee354_2048_btn_ctrl
// Front end of the 2048 game: converts four raw, bouncing push buttons into
// clean one-hot single-cycle move pulses. A move is only issued while the game
// FSM sits in WAIT. After issuing, the block follows the game's WAIT->move->WAIT
// handshake and waits for every button to be released before it accepts
// another press, so a held button never repeats.

module ee354_2048_btn_ctrl #(
    parameter int DB_LIMIT    = 500000,
    parameter int DB_W        = 19,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        BtnU,
    input  logic        BtnD,
    input  logic        BtnL,
    input  logic        BtnR,
    input  logic        q_Wait,
    output logic        up,
    output logic        down,
    output logic        left,
    output logic        right,
    output logic        busy,
    output logic [1:0]  last_dir,
    output logic [15:0] move_count,
    output logic        ack_err
);

    // Debounce terminal count: the stable level flips on the DB_LIMIT-th
    // consecutive cycle that the synchronised input disagrees with it.
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_LIMIT - 1);

    // The ACK counter only has to reach ACK_TIMEOUT-1.
    localparam int ACK_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_ACK_WAIT = 2'd2,
        S_RELEASE  = 2'd3
    } state_t;

    // Bit order everywhere: 0 = up, 1 = down, 2 = left, 3 = right.
    logic [3:0] btn_raw;
    logic [3:0] stable_vec;
    logic [3:0] press;

    assign btn_raw = {BtnR, BtnL, BtnD, BtnU};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_btn
            logic            s1_reg;
            logic            s2_reg;
            logic            stable_reg;
            logic            stable_d_reg;
            logic [DB_W-1:0] db_cnt_reg;

            // Synchronise the raw button, debounce it, and keep a delayed copy for edge detection
            always_ff @(posedge Clk or negedge Reset_n) begin
                if (!Reset_n) begin
                    s1_reg       <= 1'b0;
                    s2_reg       <= 1'b0;
                    stable_reg   <= 1'b0;
                    stable_d_reg <= 1'b0;
                    db_cnt_reg   <= '0;
                end else begin
                    s1_reg       <= btn_raw[gi];
                    s2_reg       <= s1_reg;
                    stable_d_reg <= stable_reg;
                    if (s2_reg == stable_reg) begin
                        // Agreement (or a glitch ending) restarts the count.
                        db_cnt_reg <= '0;
                    end else if (db_cnt_reg == DB_LAST) begin
                        stable_reg <= s2_reg;
                        db_cnt_reg <= '0;
                    end else begin
                        db_cnt_reg <= db_cnt_reg + DB_W'(1);
                    end
                end
            end

            assign stable_vec[gi] = stable_reg;
            assign press[gi]      = stable_reg & ~stable_d_reg;
        end
    endgenerate

    state_t           state_reg, state_next;
    logic [1:0]       dir_reg, dir_next;
    logic [ACK_W-1:0] ack_cnt_reg, ack_cnt_next;
    logic [3:0]       pulse_reg, pulse_next;
    logic [1:0]       last_dir_reg, last_dir_next;
    logic [15:0]      move_count_reg, move_count_next;
    logic             ack_err_reg, ack_err_next;

    // Move FSM: next state, selected direction, pulse and bookkeeping updates
    always_comb begin
        state_next      = state_reg;
        dir_next        = dir_reg;
        ack_cnt_next    = ack_cnt_reg;
        pulse_next      = 4'b0000;
        last_dir_next   = last_dir_reg;
        move_count_next = move_count_reg;
        ack_err_next    = ack_err_reg;

        case (state_reg)
            S_IDLE: begin
                // Presses outside IDLE or while the game is busy are simply lost.
                if (q_Wait && (press != 4'b0000)) begin
                    if (press[0]) begin
                        dir_next = 2'd0;
                    end else if (press[1]) begin
                        dir_next = 2'd1;
                    end else if (press[2]) begin
                        dir_next = 2'd2;
                    end else begin
                        dir_next = 2'd3;
                    end
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                pulse_next[dir_reg] = 1'b1;
                last_dir_next       = dir_reg;
                move_count_next     = move_count_reg + 16'd1;
                ack_cnt_next        = '0;
                state_next          = S_ACK_WAIT;
            end
            S_ACK_WAIT: begin
                if (!q_Wait) begin
                    state_next = S_RELEASE;
                end else if (ack_cnt_reg == ACK_LAST) begin
                    // Game never left WAIT: flag it and carry on rather than hang.
                    ack_err_next = 1'b1;
                    state_next   = S_RELEASE;
                end else begin
                    ack_cnt_next = ack_cnt_reg + ACK_W'(1);
                end
            end
            S_RELEASE: begin
                // WIN/LOSE keeps q_Wait low, which parks the block here.
                if (q_Wait && (stable_vec == 4'b0000)) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // FSM and output registers; reset clears any in-flight pulse immediately
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg      <= S_IDLE;
            dir_reg        <= 2'd0;
            ack_cnt_reg    <= '0;
            pulse_reg      <= 4'b0000;
            last_dir_reg   <= 2'd0;
            move_count_reg <= 16'd0;
            ack_err_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            dir_reg        <= dir_next;
            ack_cnt_reg    <= ack_cnt_next;
            pulse_reg      <= pulse_next;
            last_dir_reg   <= last_dir_next;
            move_count_reg <= move_count_next;
            ack_err_reg    <= ack_err_next;
        end
    end

    assign up         = pulse_reg[0];
    assign down       = pulse_reg[1];
    assign left       = pulse_reg[2];
    assign right      = pulse_reg[3];
    assign busy       = (state_reg != S_IDLE);
    assign last_dir   = last_dir_reg;
    assign move_count = move_count_reg;
    assign ack_err    = ack_err_reg;

endmodule

// File: tb/tb_ee354_2048_btn_ctrl.sv
// Bench for ee354_2048_btn_ctrl with DB_LIMIT=4, ACK_TIMEOUT=4.
// A reference model (button history windows plus a move-handshake tracker) is
// stepped and compared every cycle; directed scenarios add literal checks.

module tb_ee354_2048_btn_ctrl;

    localparam int LIM = 4;
    localparam int TMO = 4;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        BtnU, BtnD, BtnL, BtnR;
    logic        q_Wait;
    logic        up, down, left, right;
    logic        busy;
    logic [1:0]  last_dir;
    logic [15:0] move_count;
    logic        ack_err;

    ee354_2048_btn_ctrl #(
        .DB_LIMIT   (LIM),
        .DB_W       (3),
        .ACK_TIMEOUT(TMO)
    ) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .BtnU      (BtnU),
        .BtnD      (BtnD),
        .BtnL      (BtnL),
        .BtnR      (BtnR),
        .q_Wait    (q_Wait),
        .up        (up),
        .down      (down),
        .left      (left),
        .right     (right),
        .busy      (busy),
        .last_dir  (last_dir),
        .move_count(move_count),
        .ack_err   (ack_err)
    );

    always #5 Clk = ~Clk;

    int total;
    int bad;
    int cyc;
    int npulse [4];
    int pulse_cyc [4];
    int total_pulses;

    // Game FSM stand-in: 0 = WAIT model, 1 = q_Wait stuck high, 2 = stuck low
    int game_mode;
    int g_delay;
    int g_low;

    // Reference model state
    logic [LIM+1:0] m_hist [4];   // bit 0 newest raw sample
    logic [3:0]     m_stable;
    logic [3:0]     m_press;
    int             m_ph;         // 0 idle, 1 issue, 2 waiting for ack, 3 waiting for release
    int             m_pick;
    int             m_wait;
    logic [1:0]     m_last;
    logic [15:0]    m_cnt;
    logic           m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cycle %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 4; b++) m_hist[b] = '0;
        m_stable = 4'b0;
        m_press  = 4'b0;
        m_ph     = 0;
        m_pick   = 0;
        m_wait   = 0;
        m_last   = 2'd0;
        m_cnt    = 16'd0;
        m_err    = 1'b0;
    endtask

    // Advance the model over one rising edge and compare every output.
    task automatic model_step();
        logic [3:0] raw;
        logic [3:0] exp_p;
        logic [3:0] rose;
        raw   = {BtnR, BtnL, BtnD, BtnU};
        exp_p = 4'b0;
        if (!Reset_n) begin
            model_reset();
        end else begin
            case (m_ph)
                0: if (q_Wait && m_press != 4'b0) begin
                       m_pick = m_press[0] ? 0 : m_press[1] ? 1 : m_press[2] ? 2 : 3;
                       m_ph   = 1;
                   end
                1: begin
                       exp_p[m_pick] = 1'b1;
                       m_last = 2'(m_pick);
                       m_cnt  = m_cnt + 16'd1;
                       m_wait = 0;
                       m_ph   = 2;
                   end
                2: if (!q_Wait) m_ph = 3;
                   else begin
                       m_wait++;
                       if (m_wait == TMO) begin
                           m_err = 1'b1;
                           m_ph  = 3;
                       end
                   end
                default: if (q_Wait && m_stable == 4'b0) m_ph = 0;
            endcase
            // A level is accepted once the two-cycle-delayed input has disagreed
            // with it for LIM consecutive samples.
            rose = 4'b0;
            for (int b = 0; b < 4; b++) begin
                m_hist[b] = {m_hist[b][LIM:0], raw[b]};
                if (m_hist[b][LIM+1:2] == {LIM{~m_stable[b]}}) begin
                    m_stable[b] = ~m_stable[b];
                    rose[b]     = m_stable[b];
                end
            end
            m_press = rose;
        end
        check("pulses", 32'({right, left, down, up}), 32'(exp_p));
        check("busy", 32'(busy), (m_ph != 0) ? 32'd1 : 32'd0);
        check("last_dir", 32'(last_dir), 32'(m_last));
        check("move_count", 32'(move_count), 32'(m_cnt));
        check("ack_err", 32'(ack_err), 32'(m_err));
    endtask

    task automatic game_drive();
        case (game_mode)
            1: begin q_Wait = 1'b1; g_delay = 0; g_low = 0; end
            2: begin q_Wait = 1'b0; g_delay = 0; g_low = 0; end
            default: begin
                if (g_delay != 0) begin
                    g_delay = 0;
                    g_low   = 2;
                end else if (g_low > 0) begin
                    g_low--;
                end
                q_Wait = (g_low == 0);
                if (up | down | left | right) g_delay = 1;
            end
        endcase
    endtask

    task automatic cycle();
        logic [3:0] p;
        @(posedge Clk);
        #1;
        cyc++;
        model_step();
        p = {right, left, down, up};
        for (int d = 0; d < 4; d++) begin
            if (p[d]) begin
                npulse[d]++;
                pulse_cyc[d] = cyc;
                total_pulses++;
                $display("cycle %0d: move dir=%0d move_count=%0d", cyc, d, move_count);
            end
        end
        @(negedge Clk);
        game_drive();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        BtnU = 1'b0; BtnD = 1'b0; BtnL = 1'b0; BtnR = 1'b0;
        game_mode = 0;
        Reset_n = 1'b0;
        run(3);
        Reset_n = 1'b1;
        run(2);
    endtask

    initial begin
        int t0;
        int tp;
        int base;
        total = 0; bad = 0; cyc = 0; total_pulses = 0;
        for (int d = 0; d < 4; d++) begin npulse[d] = 0; pulse_cyc[d] = -100; end
        game_mode = 0; g_delay = 0; g_low = 0;
        q_Wait = 1'b1;
        BtnU = 1'b0; BtnD = 1'b0; BtnL = 1'b0; BtnR = 1'b0;
        Reset_n = 1'b0;
        model_reset();
        #1;
        check("reset_pulses", 32'({right, left, down, up}), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_count", 32'(move_count), 32'd0);
        check("reset_err", 32'(ack_err), 32'd0);
        run(3);
        Reset_n = 1'b1;
        run(2);

        // Clean press of left held 20 cycles
        tp = total_pulses; base = npulse[2];
        BtnL = 1'b1; t0 = cyc;
        run(20);
        BtnL = 1'b0;
        run(15);
        check("clean_latency", pulse_cyc[2] - t0, 8);
        check("clean_left_count", npulse[2] - base, 1);
        check("clean_total_pulses", total_pulses - tp, 1);
        check("clean_last_dir", 32'(last_dir), 32'd2);
        check("clean_move_count", 32'(move_count), 32'd1);
        check("clean_idle", 32'(busy), 32'd0);

        // Bouncing up button, then held
        do_reset();
        tp = total_pulses;
        for (int i = 0; i < 12; i++) begin
            BtnU = ((i / 2) % 2 == 0);
            run(1);
        end
        BtnU = 1'b1; t0 = cyc;
        run(20);
        BtnU = 1'b0;
        run(15);
        check("bounce_latency", pulse_cyc[0] - t0, 8);
        check("bounce_pulses", total_pulses - tp, 1);
        check("bounce_move_count", 32'(move_count), 32'd1);

        // Simultaneous down+right, then right alone
        do_reset();
        base = npulse[3]; tp = npulse[1];
        BtnD = 1'b1; BtnR = 1'b1;
        run(15);
        check("simul_down", npulse[1] - tp, 1);
        check("simul_right_dropped", npulse[3] - base, 0);
        BtnD = 1'b0; BtnR = 1'b0;
        run(15);
        BtnR = 1'b1;
        run(15);
        BtnR = 1'b0;
        run(15);
        check("simul_right_later", npulse[3] - base, 1);
        check("simul_move_count", 32'(move_count), 32'd2);
        check("simul_last_dir", 32'(last_dir), 32'd3);

        // Stalled game: q_Wait never falls
        do_reset();
        game_mode = 1;
        run(1);
        base = npulse[0];
        BtnU = 1'b1; t0 = cyc;
        run(11);
        check("stall_latency", pulse_cyc[0] - t0, 8);
        check("stall_err_before", 32'(ack_err), 32'd0);
        run(1);
        check("stall_err_set", 32'(ack_err), 32'd1);
        check("stall_busy", 32'(busy), 32'd1);
        run(5);
        BtnU = 1'b0;
        run(10);
        check("stall_back_idle", 32'(busy), 32'd0);
        BtnU = 1'b1;
        run(10);
        check("stall_second_move", npulse[0] - base, 2);
        check("stall_move_count", 32'(move_count), 32'd2);
        BtnU = 1'b0;
        run(15);
        check("stall_err_sticky", 32'(ack_err), 32'd1);
        game_mode = 0;

        // Game over: q_Wait stays low after a move, then reset mid-stall
        do_reset();
        BtnL = 1'b1;
        run(10);
        game_mode = 2;
        BtnL = 1'b0;
        run(12);
        tp = total_pulses;
        BtnD = 1'b1;
        run(15);
        check("gameover_no_pulse", total_pulses - tp, 0);
        check("gameover_busy", 32'(busy), 32'd1);
        check("gameover_count", 32'(move_count), 32'd1);
        Reset_n = 1'b0;
        #1;
        check("rst_mid_pulses", 32'({right, left, down, up}), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_count", 32'(move_count), 32'd0);
        check("rst_mid_last_dir", 32'(last_dir), 32'd0);
        check("rst_mid_err", 32'(ack_err), 32'd0);
        run(2);
        BtnD = 1'b0;
        game_mode = 0;
        Reset_n = 1'b1;
        run(3);

        // Reset while a pulse is on the output
        do_reset();
        BtnL = 1'b1;
        run(8);
        check("inflight_pulse_high", 32'(left), 32'd1);
        Reset_n = 1'b0;
        #1;
        check("inflight_pulse_dropped", 32'(left), 32'd0);
        check("inflight_count", 32'(move_count), 32'd0);
        run(2);
        BtnL = 1'b0;
        Reset_n = 1'b1;
        run(3);

        // Move counter wrap
        do_reset();
        force dut.move_count_reg = 16'hFFFF;
        m_cnt = 16'hFFFF;
        run(2);
        release dut.move_count_reg;
        run(1);
        check("wrap_preload", 32'(move_count), 32'h0000FFFF);
        BtnR = 1'b1; t0 = cyc;
        run(12);
        check("wrap_latency", pulse_cyc[3] - t0, 8);
        check("wrap_count", 32'(move_count), 32'd0);
        check("wrap_last_dir", 32'(last_dir), 32'd3);
        BtnR = 1'b0;
        run(15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
